rf_wport_arb: RTL and testbench
===============================

Name: rf_wport_arb

Overview:
- Arbitrates the single register-file write port between the in-order writeback stage (WS) and a long-latency unit (LU), such as a multi-cycle divider or an uncached load return.
- Each granted request is registered for one cycle, then driven to the register file and to the debug trace interface.
- WS has default priority. A starvation FSM forces an LU grant after STARVE_LIMIT consecutive lost cycles.

Parameters:
STARVE_LIMIT, 4, consecutive cycles LU may be blocked before it gets forced priority (legal range 1..2^CNT_W-1)
CNT_W, 3, width of the starvation counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
ws_req_valid  input  1  WS has a retiring instruction
ws_req_we  input  1  the WS instruction writes a GPR
ws_req_dest  input  5  WS destination register
ws_req_wdata  input  32  WS write data
ws_req_pc  input  32  WS instruction PC
ws_req_ready  output  1  WS request accepted this cycle (combinational)
lu_req_valid  input  1  LU has a result pending
lu_req_dest  input  5  LU destination register
lu_req_wdata  input  32  LU result
lu_req_pc  input  32  PC of the originating LU instruction
lu_req_ready  output  1  LU request accepted this cycle (combinational)
rf_we  output  1  register-file write enable (registered)
rf_waddr  output  5  register-file write address (registered)
rf_wdata  output  32  register-file write data (registered)
debug_wb_pc  output  32  trace PC of the committed slot
debug_wb_rf_wen  output  4  trace write enable, {4{rf_we}}
debug_wb_rf_wnum  output  5  trace destination, equal to rf_waddr
debug_wb_rf_wdata  output  32  trace data, equal to rf_wdata

Behaviour:
- Transfer occurs on valid & ready for each requester. At most one grant per cycle.
- Every WS instruction occupies a port slot, including those with ws_req_we=0, so each retirement produces exactly one trace slot.
- The LU always writes: its effective we is 1.
- FSM has two states:
  - WS_PRI (reset state): ws_req_ready = 1; lu_req_ready = ~ws_req_valid.
  - LU_PRI: lu_req_ready = 1; ws_req_ready = ~lu_req_valid.
- Starvation counter starv_cnt (CNT_W bits):
  - reset to 0;
  - increments when lu_req_valid & ~lu_req_ready;
  - clears on any LU grant, or when lu_req_valid=0;
  - saturates at STARVE_LIMIT.
- FSM transitions:
  - WS_PRI -> LU_PRI when the next starv_cnt value equals STARVE_LIMIT.
  - LU_PRI -> WS_PRI on the cycle after an LU grant.
  - LU_PRI -> WS_PRI if lu_req_valid drops before a grant.
- Output register:
  - On a grant at cycle N, rf_we/rf_waddr/rf_wdata/debug_wb_pc update at edge N+1. Latency is exactly 1 cycle.
  - With no grant in a cycle, rf_we = 0 next cycle, and rf_waddr/rf_wdata/debug_wb_pc hold their previous values.
- Register zero: a granted write with dest == 0 is registered with rf_we = 0. Its PC still appears on debug_wb_pc.
- Simultaneous valid from both requesters: the priority owner is granted; the other stalls with ready = 0 and must hold its request stable.
- Reset at any point, including mid-stall: FSM = WS_PRI, starv_cnt = 0, all outputs 0. No partial write leaks out.
- The block applies no RAW ordering between the two requesters. Hazard checks on pending LU destinations are done upstream.

Optional Feature:
- RF_ARB_PERF_EN defined:
  - adds output ports perf_ws_stall_cnt [31:0] and perf_lu_stall_cnt [31:0];
  - each counts cycles its requester had valid & ~ready;
  - counters wrap at 2^32 and reset to 0.
- RF_ARB_PERF_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- WS only: valid with we=1, dest=5, wdata=0x1234, pc=0x1c000000 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, debug_wb_rf_wen=4'hf, debug_wb_pc=0x1c000000.
- Collision: WS and LU both valid, FSM in WS_PRI -> WS granted, lu_req_ready=0; a cycle later WS idle -> LU (dest=7, 0xdead) is written.
- Starvation: LU valid and WS valid every cycle, STARVE_LIMIT=4 -> LU blocked for cycles 0-3; cycle 4 gives lu_req_ready=1 and ws_req_ready=0; LU data appears at cycle 5; FSM is back in WS_PRI by cycle 6.
- Non-writing and r0 cases: WS we=0 at pc=0x1c000010 -> debug_wb_pc=0x1c000010 with wen=0. LU dest=0 -> rf_we=0.
- Async reset: assert reset mid-stall while in LU_PRI -> all outputs 0 immediately, before the next clock edge; after release the FSM is in WS_PRI and the first WS request is granted.
- With RF_ARB_PERF_EN: 3 LU stall cycles -> perf_lu_stall_cnt=3 and perf_ws_stall_cnt=0.

Source files
------------

// File: rtl/rf_wport_arb.sv
// ---------------------------------------------------------------------------
// rf_wport_arb
// Arbitrates the single register-file write port between the in-order
// writeback stage (WS) and a long-latency unit (LU). WS owns the port by
// default; a starvation counter hands priority to LU after STARVE_LIMIT
// consecutive blocked cycles. Each grant is registered for one cycle and then
// driven to the register file and the debug trace interface.
//
// Optional build macro: RF_ARB_PERF_EN adds perf_ws_stall_cnt/perf_lu_stall_cnt.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   ws_req_*                   WS request (valid/we/dest/wdata/pc), ws_req_ready
//   lu_req_*                   LU request (valid/dest/wdata/pc), lu_req_ready
//   rf_we/rf_waddr/rf_wdata    registered register-file write port
//   debug_wb_*                 trace copy of the committed slot
//   perf_*_stall_cnt           (RF_ARB_PERF_EN) valid & ~ready cycle counters
// ---------------------------------------------------------------------------
module rf_wport_arb #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_req_valid,
    input  logic        ws_req_we,
    input  logic [4:0]  ws_req_dest,
    input  logic [31:0] ws_req_wdata,
    input  logic [31:0] ws_req_pc,
    output logic        ws_req_ready,
    input  logic        lu_req_valid,
    input  logic [4:0]  lu_req_dest,
    input  logic [31:0] lu_req_wdata,
    input  logic [31:0] lu_req_pc,
    output logic        lu_req_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
`ifdef RF_ARB_PERF_EN
    ,
    output logic [31:0] perf_ws_stall_cnt,
    output logic [31:0] perf_lu_stall_cnt
`endif
);

    typedef enum logic {WS_PRI = 1'b0, LU_PRI = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_starv_cnt, w_starv_nxt;
    logic             w_ws_grant, w_lu_grant;

    logic             r_we;
    logic [4:0]       r_waddr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_pc;

    // Ready generation and grants: the priority owner is always ready, the
    // other side only when the owner is idle, so at most one grant per cycle.
    always_comb begin
        ws_req_ready = 1'b1;
        lu_req_ready = ~ws_req_valid;
        if (r_state == LU_PRI) begin
            lu_req_ready = 1'b1;
            ws_req_ready = ~lu_req_valid;
        end
    end

    assign w_ws_grant = ws_req_valid & ws_req_ready;
    assign w_lu_grant = lu_req_valid & lu_req_ready;

    // Starvation counter: counts consecutive blocked LU cycles, saturating.
    always_comb begin
        w_starv_nxt = r_starv_cnt;
        if (!lu_req_valid || w_lu_grant)
            w_starv_nxt = '0;
        else if (r_starv_cnt != LIMIT)
            w_starv_nxt = r_starv_cnt + CNT_W'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WS_PRI: if (w_starv_nxt == LIMIT) w_state_nxt = LU_PRI;
            // Leave on the grant itself, or if LU withdrew before being served.
            LU_PRI: if (w_lu_grant || !lu_req_valid) w_state_nxt = WS_PRI;
            default: w_state_nxt = WS_PRI;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= WS_PRI;
            r_starv_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_starv_cnt <= w_starv_nxt;
        end
    end

    // Output slot register. A write to r0 still occupies a trace slot (PC and
    // address update) but with the write enable suppressed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_pc    <= '0;
        end else if (w_ws_grant) begin
            r_we    <= ws_req_we & (ws_req_dest != 5'd0);
            r_waddr <= ws_req_dest;
            r_wdata <= ws_req_wdata;
            r_pc    <= ws_req_pc;
        end else if (w_lu_grant) begin
            r_we    <= (lu_req_dest != 5'd0);
            r_waddr <= lu_req_dest;
            r_wdata <= lu_req_wdata;
            r_pc    <= lu_req_pc;
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign rf_we             = r_we;
    assign rf_waddr          = r_waddr;
    assign rf_wdata          = r_wdata;
    assign debug_wb_pc       = r_pc;
    assign debug_wb_rf_wen   = {4{r_we}};
    assign debug_wb_rf_wnum  = r_waddr;
    assign debug_wb_rf_wdata = r_wdata;

`ifdef RF_ARB_PERF_EN
    logic [31:0] r_perf_ws, r_perf_lu;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_ws <= '0;
            r_perf_lu <= '0;
        end else begin
            if (ws_req_valid && !ws_req_ready) r_perf_ws <= r_perf_ws + 32'd1;
            if (lu_req_valid && !lu_req_ready) r_perf_lu <= r_perf_lu + 32'd1;
        end
    end

    assign perf_ws_stall_cnt = r_perf_ws;
    assign perf_lu_stall_cnt = r_perf_lu;
`endif

endmodule

// File: tb/tb_rf_wport_arb.sv
module tb_rf_wport_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_req_valid, ws_req_we;
    logic [4:0]  ws_req_dest;
    logic [31:0] ws_req_wdata, ws_req_pc;
    logic        ws_req_ready;
    logic        lu_req_valid;
    logic [4:0]  lu_req_dest;
    logic [31:0] lu_req_wdata, lu_req_pc;
    logic        lu_req_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
`ifdef RF_ARB_PERF_EN
    logic [31:0] perf_ws_stall_cnt, perf_lu_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_wport_arb #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .ws_req_valid(ws_req_valid), .ws_req_we(ws_req_we), .ws_req_dest(ws_req_dest),
        .ws_req_wdata(ws_req_wdata), .ws_req_pc(ws_req_pc), .ws_req_ready(ws_req_ready),
        .lu_req_valid(lu_req_valid), .lu_req_dest(lu_req_dest), .lu_req_wdata(lu_req_wdata),
        .lu_req_pc(lu_req_pc), .lu_req_ready(lu_req_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`ifdef RF_ARB_PERF_EN
        , .perf_ws_stall_cnt(perf_ws_stall_cnt), .perf_lu_stall_cnt(perf_lu_stall_cnt)
`endif
    );

    // Inputs change 1ns after the rising edge; readies are sampled 1ns later,
    // registered outputs 1ns after the following edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ws(input logic v, input logic we, input logic [4:0] d,
                          input logic [31:0] data, input logic [31:0] pc);
        ws_req_valid = v; ws_req_we = we; ws_req_dest = d;
        ws_req_wdata = data; ws_req_pc = pc;
    endtask

    task automatic set_lu(input logic v, input logic [4:0] d,
                          input logic [31:0] data, input logic [31:0] pc);
        lu_req_valid = v; lu_req_dest = d; lu_req_wdata = data; lu_req_pc = pc;
    endtask

    task automatic test_reset();
        set_ws(0, 0, 0, 0, 0);
        set_lu(0, 0, 0, 0);
        reset = 1'b1;
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, debug_wb_pc} !== 70'd0) begin
            errors++; $display("FAIL reset_outputs we=%b addr=%0d data=%h pc=%h required all 0", rf_we, rf_waddr, rf_wdata, debug_wb_pc);
        end
        checks++;
        if ({debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata} !== 41'd0) begin
            errors++; $display("FAIL reset_trace wen=%h wnum=%0d wdata=%h required all 0", debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata);
        end
        next_cycle(); next_cycle();
        reset = 1'b0;
        next_cycle();
        #1;
        checks++;
        if ({ws_req_ready, lu_req_ready} !== 2'b11) begin
            errors++; $display("FAIL reset_idle_ready got ws=%b lu=%b required 1 1", ws_req_ready, lu_req_ready);
        end
    endtask

    task automatic test_ws_only();
        set_ws(1, 1, 5'd5, 32'h1234, 32'h1c000000);
        #1;
        checks++;
        if (ws_req_ready !== 1'b1) begin
            errors++; $display("FAIL ws_only_ready got %b required 1", ws_req_ready);
        end
        next_cycle();
        set_ws(0, 0, 0, 0, 0);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234 ||
            debug_wb_rf_wen !== 4'hf || debug_wb_pc !== 32'h1c000000) begin
            errors++; $display("FAIL ws_only_write got we=%b addr=%0d data=%h wen=%h pc=%h required 1 5 1234 f 1c000000",
                               rf_we, rf_waddr, rf_wdata, debug_wb_rf_wen, debug_wb_pc);
        end
        checks++;
        if (debug_wb_rf_wnum !== 5'd5 || debug_wb_rf_wdata !== 32'h1234) begin
            errors++; $display("FAIL ws_only_trace got wnum=%0d wdata=%h required 5 1234", debug_wb_rf_wnum, debug_wb_rf_wdata);
        end
        #1;
        next_cycle();
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234 || debug_wb_pc !== 32'h1c000000) begin
            errors++; $display("FAIL idle_hold got we=%b addr=%0d data=%h pc=%h required 0 5 1234 1c000000",
                               rf_we, rf_waddr, rf_wdata, debug_wb_pc);
        end
    endtask

    task automatic test_collision();
        set_ws(1, 1, 5'd3, 32'h1111, 32'h1c000004);
        set_lu(1, 5'd7, 32'hdead, 32'h1c000100);
        #1;
        checks++;
        if ({ws_req_ready, lu_req_ready} !== 2'b10) begin
            errors++; $display("FAIL collision_ready got ws=%b lu=%b required 1 0", ws_req_ready, lu_req_ready);
        end
        next_cycle();
        set_ws(0, 0, 0, 0, 0);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h1111) begin
            errors++; $display("FAIL collision_ws_write got we=%b addr=%0d data=%h required 1 3 1111", rf_we, rf_waddr, rf_wdata);
        end
        #1;
        checks++;
        if (lu_req_ready !== 1'b1) begin
            errors++; $display("FAIL collision_lu_ready got %b required 1", lu_req_ready);
        end
        next_cycle();
        set_lu(0, 0, 0, 0);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hdead || debug_wb_pc !== 32'h1c000100) begin
            errors++; $display("FAIL collision_lu_write got we=%b addr=%0d data=%h pc=%h required 1 7 dead 1c000100",
                               rf_we, rf_waddr, rf_wdata, debug_wb_pc);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        set_ws(1, 1, 5'd2, 32'h2222, 32'h1c000200);
        set_lu(1, 5'd9, 32'hbeef, 32'h1c000300);
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if ({ws_req_ready, lu_req_ready} !== 2'b10) begin
                errors++; $display("FAIL starve_blocked c%0d got ws=%b lu=%b required 1 0", c, ws_req_ready, lu_req_ready);
            end
            next_cycle();
            checks++;
            if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h2222) begin
                errors++; $display("FAIL starve_ws_write c%0d got we=%b addr=%0d data=%h required 1 2 2222", c, rf_we, rf_waddr, rf_wdata);
            end
        end
        #1;
        checks++;
        if ({ws_req_ready, lu_req_ready} !== 2'b01) begin
            errors++; $display("FAIL starve_forced c4 got ws=%b lu=%b required 0 1", ws_req_ready, lu_req_ready);
        end
        next_cycle();
        set_lu(1, 5'd10, 32'hcafe, 32'h1c000304);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hbeef || debug_wb_pc !== 32'h1c000300) begin
            errors++; $display("FAIL starve_lu_write c5 got we=%b addr=%0d data=%h pc=%h required 1 9 beef 1c000300",
                               rf_we, rf_waddr, rf_wdata, debug_wb_pc);
        end
        #1;
        checks++;
        if ({ws_req_ready, lu_req_ready} !== 2'b10) begin
            errors++; $display("FAIL starve_back_ws_pri c5 got ws=%b lu=%b required 1 0", ws_req_ready, lu_req_ready);
        end
        next_cycle();
        set_ws(0, 0, 0, 0, 0);
        set_lu(0, 0, 0, 0);
        next_cycle();
    endtask

    task automatic test_nowrite_r0();
        set_ws(1, 0, 5'd9, 32'h9999, 32'h1c000010);
        next_cycle();
        set_ws(0, 0, 0, 0, 0);
        set_lu(1, 5'd0, 32'h55, 32'h1c000020);
        checks++;
        if (rf_we !== 1'b0 || debug_wb_rf_wen !== 4'h0 || debug_wb_pc !== 32'h1c000010) begin
            errors++; $display("FAIL ws_we0 got we=%b wen=%h pc=%h required 0 0 1c000010", rf_we, debug_wb_rf_wen, debug_wb_pc);
        end
        next_cycle();
        set_lu(0, 0, 0, 0);
        checks++;
        if (rf_we !== 1'b0 || debug_wb_rf_wen !== 4'h0 || debug_wb_pc !== 32'h1c000020) begin
            errors++; $display("FAIL lu_r0 got we=%b wen=%h pc=%h required 0 0 1c000020", rf_we, debug_wb_rf_wen, debug_wb_pc);
        end
        next_cycle();
    endtask

    task automatic test_async_reset();
        set_ws(1, 1, 5'd6, 32'h6666, 32'h1c000400);
        set_lu(1, 5'd11, 32'h7777, 32'h1c000500);
        for (int c = 0; c < 4; c++) next_cycle();
        #1;
        checks++;
        if ({ws_req_ready, lu_req_ready, rf_we} !== 3'b011) begin
            errors++; $display("FAIL pre_reset_lu_pri got ws=%b lu=%b we=%b required 0 1 1", ws_req_ready, lu_req_ready, rf_we);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, debug_wb_pc, debug_wb_rf_wen} !== 74'd0) begin
            errors++; $display("FAIL async_reset got we=%b addr=%0d data=%h pc=%h wen=%h required all 0",
                               rf_we, rf_waddr, rf_wdata, debug_wb_pc, debug_wb_rf_wen);
        end
        next_cycle();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, debug_wb_pc} !== 70'd0) begin
            errors++; $display("FAIL reset_held_edge got we=%b addr=%0d data=%h pc=%h required all 0", rf_we, rf_waddr, rf_wdata, debug_wb_pc);
        end
        reset = 1'b0;
        set_ws(1, 1, 5'd4, 32'habc, 32'h1c000600);
        #1;
        checks++;
        if ({ws_req_ready, lu_req_ready} !== 2'b10) begin
            errors++; $display("FAIL post_reset_ws_pri got ws=%b lu=%b required 1 0", ws_req_ready, lu_req_ready);
        end
        next_cycle();
        set_ws(0, 0, 0, 0, 0);
        set_lu(0, 0, 0, 0);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'habc || debug_wb_pc !== 32'h1c000600) begin
            errors++; $display("FAIL post_reset_write got we=%b addr=%0d data=%h pc=%h required 1 4 abc 1c000600",
                               rf_we, rf_waddr, rf_wdata, debug_wb_pc);
        end
        next_cycle();
    endtask

`ifdef RF_ARB_PERF_EN
    task automatic test_perf();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        set_ws(1, 1, 5'd1, 32'h1, 32'h1c000700);
        set_lu(1, 5'd12, 32'h12, 32'h1c000800);
        for (int c = 0; c < 3; c++) next_cycle();
        set_ws(0, 0, 0, 0, 0);
        set_lu(0, 0, 0, 0);
        next_cycle();
        checks++;
        if (perf_lu_stall_cnt !== 32'd3 || perf_ws_stall_cnt !== 32'd0) begin
            errors++; $display("FAIL perf_counts got lu=%0d ws=%0d required 3 0", perf_lu_stall_cnt, perf_ws_stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ws_only();
        test_collision();
        test_starvation();
        test_nowrite_r0();
        test_async_reset();
`ifdef RF_ARB_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
